// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave.
package apb_pkg;

    // Transfer FSM: IDLE waits for a setup phase, ACCESS runs wait states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    // Width of the wait-state counter (WAIT_STATES may be 0..15).
    localparam int unsigned CNT_W = 4;

    // pslverr response encodings.
    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_sp_ram.sv
// Single-port DEPTH x DATAWIDTH memory with synchronous read and per-byte
// write enables. A port cycle is either a read or a write, selected by we.
module apb_sp_ram #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [DATAWIDTH/8-1:0]   be,
    input  logic [RAM_AW-1:0]        addr,
    input  logic [DATAWIDTH-1:0]     wdata,
    output logic [DATAWIDTH-1:0]     rdata
);

    localparam int unsigned NB = DATAWIDTH / 8;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    // Byte-lane writes or a registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave in front of a DEPTH-word on-chip RAM with configurable wait
// states and address-range error response on pslverr.
// Optional feature: define APB_PSTRB_EN to add the pstrb port and byte-lane
// write masking; without it every write updates the full word.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = 12,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRWIDTH-1:0]     paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [DATAWIDTH-1:0]     pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATAWIDTH/8-1:0]   pstrb,
`endif
    output logic [DATAWIDTH-1:0]     prdata,
    output logic                     pready,
    output logic                     pslverr
);

    localparam int unsigned NB     = DATAWIDTH / 8;
    localparam int unsigned OFFS   = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDXW   = ADDRWIDTH - OFFS;
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] WS_CNT  = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] WS_LAST = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rd_zero_q;

    logic [IDXW-1:0]       idx;
    logic                  addr_err;
    logic                  ready;
    logic                  setup;
    logic                  live;
    logic                  rd_issue;
    logic                  rd_err_now;
    logic                  wr_commit;
    logic                  ram_en;
    logic [NB-1:0]         ram_be;
    logic [DATAWIDTH-1:0]  ram_rdata;

    // Word decode: byte-offset bits are dropped, index beyond DEPTH is an error.
    assign idx      = paddr[ADDRWIDTH-1:OFFS];
    assign addr_err = (32'(idx) >= 32'(DEPTH));

    generate
        if (OFFS > 0) begin : g_offset
            logic unused_offset;
            assign unused_offset = ^paddr[OFFS-1:0];
        end
    endgenerate

    assign setup = psel & ~penable;
    assign live  = psel & penable;
    assign ready = (state_q == ACCESS) && (cnt_q == WS_CNT);

    // State, wait counter and latched address-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic plus read-issue and write-commit strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rd_issue   = 1'b0;
        rd_err_now = 1'b0;
        wr_commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    err_d   = addr_err;
                    // Zero-wait reads fetch at the end of setup so data is
                    // present in the single access cycle.
                    if ((WAIT_STATES == 0) && !pwrite) begin
                        rd_issue   = 1'b1;
                        rd_err_now = addr_err;
                    end
                end
            end
            ACCESS: begin
                if (ready) begin
                    state_d = IDLE;
                    if (live && pwrite && !err_q) begin
                        wr_commit = 1'b1;
                    end
                end else if (!live) begin
                    // Master dropped the transfer before completion: abort.
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((WAIT_STATES > 0) && (cnt_q == WS_LAST) && !pwrite) begin
                        rd_issue   = 1'b1;
                        rd_err_now = err_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // prdata is the RAM output register unless the last read was out of
    // range (or nothing was read since reset), in which case it reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_zero_q <= 1'b1;
        end else if (rd_issue) begin
            rd_zero_q <= rd_err_now;
        end
    end

`ifdef APB_PSTRB_EN
    assign ram_be = pstrb;
`else
    assign ram_be = '1;
`endif

    assign ram_en = ~rst & (wr_commit | (rd_issue & ~rd_err_now));

    apb_sp_ram #(
        .DEPTH     (DEPTH),
        .DATAWIDTH (DATAWIDTH),
        .RAM_AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_commit),
        .be    (ram_be),
        .addr  (idx[RAM_AW-1:0]),
        .wdata (pwdata),
        .rdata (ram_rdata)
    );

    assign prdata  = rd_zero_q ? '0 : ram_rdata;
    assign pready  = ready;
    assign pslverr = ready ? (err_q ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (zero-wait and 3-wait) driven by
// directed and random APB transfers, checked against an array memory model.
module tb_apb_mem_slave;

    localparam int unsigned WS0 = 0;
    localparam int unsigned WS1 = 3;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_w     [2];
    logic [11:0] paddr_w   [2];
    logic        psel_w    [2];
    logic        penable_w [2];
    logic        pwrite_w  [2];
    logic [31:0] pwdata_w  [2];
    logic [3:0]  pstrb_w   [2];
    logic [31:0] prdata_w  [2];
    logic        pready_w  [2];
    logic        pslverr_w [2];

    int          ws [2];
    logic [31:0] model [2][DEPTH];
    int          tests;
    int          fails;

    apb_mem_slave #(.ADDRWIDTH(12), .DATAWIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst(rst_w[0]), .paddr(paddr_w[0]), .psel(psel_w[0]),
        .penable(penable_w[0]), .pwrite(pwrite_w[0]), .pwdata(pwdata_w[0]),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb_w[0]),
`endif
        .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0])
    );

    apb_mem_slave #(.ADDRWIDTH(12), .DATAWIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst(rst_w[1]), .paddr(paddr_w[1]), .psel(psel_w[1]),
        .penable(penable_w[1]), .pwrite(pwrite_w[1]), .pwdata(pwdata_w[1]),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb_w[1]),
`endif
        .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef APB_PSTRB_EN
        return s;
`else
        return (s == s) ? 4'hF : 4'hF;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    task automatic idle(input int u, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel_w[u]    = 1'b0;
            penable_w[u] = 1'b0;
        end
    endtask

    // One APB transfer; n counts cycles from setup through the pready cycle.
    task automatic xfer(input int u, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er, output int n);
        @(posedge clk); #1;
        psel_w[u]    = 1'b1;
        penable_w[u] = 1'b0;
        pwrite_w[u]  = wr;
        paddr_w[u]   = a;
        pwdata_w[u]  = d;
        pstrb_w[u]   = s;
        n  = 0;
        rd = '0;
        er = 1'b0;
        while (n <= 40) begin
            @(negedge clk);
            n++;
            if (pready_w[u]) begin
                rd = prdata_w[u];
                er = pslverr_w[u];
                break;
            end
            @(posedge clk); #1;
            penable_w[u] = 1'b1;
        end
        chk("timeout", 64'(n <= 40), 64'd1);
    endtask

    task automatic do_write(input int u, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] rd;
        logic        er;
        int          n;
        int          idx;
        bit          exp_err;
        idx = int'(a[11:2]);
        exp_err = (idx >= DEPTH);
        xfer(u, 1'b1, a, d, s, rd, er, n);
        chk("wr_len", 64'(n), 64'(2 + ws[u]));
        chk("wr_err", 64'(er), 64'(exp_err));
        if (!exp_err) model[u][idx] = merge(model[u][idx], d, eff_strb(s));
    endtask

    task automatic do_read(input int u, input logic [11:0] a, output logic [31:0] rd);
        logic        er;
        int          n;
        int          idx;
        bit          exp_err;
        idx = int'(a[11:2]);
        exp_err = (idx >= DEPTH);
        xfer(u, 1'b0, a, 32'h0, 4'h0, rd, er, n);
        chk("rd_len", 64'(n), 64'(2 + ws[u]));
        chk("rd_err", 64'(er), 64'(exp_err));
        chk("rd_data", 64'(rd), exp_err ? 64'd0 : 64'(model[u][idx]));
    endtask

    initial begin
        logic [31:0] rd;
        bit          wr;
        int          widx;
        logic [11:0] a;
        logic [31:0] d;

        tests = 0;
        fails = 0;
        ws[0] = WS0;
        ws[1] = WS1;
        for (int u = 0; u < 2; u++) begin
            rst_w[u] = 1'b1; paddr_w[u] = '0; psel_w[u] = 1'b0; penable_w[u] = 1'b0;
            pwrite_w[u] = 1'b0; pwdata_w[u] = '0; pstrb_w[u] = 4'hF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_prdata", 64'(prdata_w[u]), 64'd0);
            chk("rst_pready", 64'(pready_w[u]), 64'd0);
            chk("rst_pslverr", 64'(pslverr_w[u]), 64'd0);
        end
        @(posedge clk); #1;
        rst_w[0] = 1'b0;
        rst_w[1] = 1'b0;

        for (int u = 0; u < 2; u++) begin
            // Initialise the words used below so every read has a known value.
            for (int w = 0; w < 32; w++) begin
                a = 12'(w * 4);
                do_write(u, a, $urandom, 4'hF);
            end

            do_write(u, 12'h010, 32'hDEADBEEF, 4'hF);
            do_read(u, 12'h010, rd);
            chk("deadbeef", 64'(rd), 64'hDEADBEEF);
            do_read(u, 12'h013, rd);
            chk("offset_ignored", 64'(rd), 64'hDEADBEEF);

            do_write(u, 12'h400, 32'h1234, 4'hF);
            do_read(u, 12'h000, rd);
            do_read(u, 12'h400, rd);
            chk("err_rd_zero", 64'(rd), 64'd0);
            do_read(u, 12'hFFC, rd);

`ifdef APB_PSTRB_EN
            do_write(u, 12'h020, 32'h0, 4'hF);
            do_write(u, 12'h020, 32'hAABBCCDD, 4'b0101);
            do_read(u, 12'h020, rd);
            chk("strb_0101", 64'(rd), 64'h00BB00DD);
            do_write(u, 12'h020, 32'h11111111, 4'b0000);
            do_read(u, 12'h020, rd);
            chk("strb_none", 64'(rd), 64'h00BB00DD);
`endif

            idle(u, 1);
            do_write(u, 12'h000, 32'h1, 4'hF);
            do_read(u, 12'h000, rd);
            chk("b2b_read", 64'(rd), 64'h1);
            idle(u, 3);
            @(negedge clk);
            chk("prdata_hold", 64'(prdata_w[u]), 64'h1);
            chk("idle_pready", 64'(pready_w[u]), 64'd0);

            for (int k = 0; k < 60; k++) begin
                wr = 1'($urandom_range(0, 1));
                widx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 1023))
                                                   : int'($urandom_range(0, 31));
                a = {widx[9:0], 2'($urandom_range(0, 3))};
                d = $urandom;
                if (wr) do_write(u, a, d, 4'($urandom_range(0, 15)));
                else    do_read(u, a, rd);
                if ($urandom_range(0, 1) == 1) idle(u, int'($urandom_range(1, 2)));
            end
            idle(u, 1);
        end

        // Reset in the access phase of a 3-wait write: the write is abandoned.
        do_read(1, 12'h014, rd);
        @(posedge clk); #1;
        psel_w[1] = 1'b1; penable_w[1] = 1'b0; pwrite_w[1] = 1'b1;
        paddr_w[1] = 12'h014; pwdata_w[1] = ~model[1][5]; pstrb_w[1] = 4'hF;
        @(posedge clk); #1;
        penable_w[1] = 1'b1;
        @(posedge clk); #1;
        rst_w[1] = 1'b1;
        @(posedge clk); #1;
        rst_w[1] = 1'b0; psel_w[1] = 1'b0; penable_w[1] = 1'b0;
        @(negedge clk);
        chk("midrst_prdata", 64'(prdata_w[1]), 64'd0);
        chk("midrst_pready", 64'(pready_w[1]), 64'd0);
        chk("midrst_pslverr", 64'(pslverr_w[1]), 64'd0);
        do_read(1, 12'h014, rd);

        // Master drops psel before pready: no write takes place.
        idle(1, 1);
        @(posedge clk); #1;
        psel_w[1] = 1'b1; penable_w[1] = 1'b0; pwrite_w[1] = 1'b1;
        paddr_w[1] = 12'h018; pwdata_w[1] = ~model[1][6]; pstrb_w[1] = 4'hF;
        @(posedge clk); #1;
        penable_w[1] = 1'b1;
        @(posedge clk); #1;
        psel_w[1] = 1'b0; penable_w[1] = 1'b0;
        @(negedge clk);
        chk("abort_pready", 64'(pready_w[1]), 64'd0);
        idle(1, 2);
        do_read(1, 12'h018, rd);
        idle(1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
